// File: rtl/uart_cmd_rcv.sv
// ---------------------------------------------------------------------------
// uart_cmd_rcv
// Serial receiver in front of the command controller. It samples the
// asynchronous RX line, assembles LSB-first bytes and holds each good byte
// behind a level cmd_rdy until the controller consumes it with clr_cmd_rdy.
// Bad stop bits and overwritten unconsumed bytes are flagged with one-cycle
// pulses so the controller can discard corrupt commands.
//
// Optional build macro: CMD_PARITY_EN
//   undefined : 8N1 frames, no parity logic
//   defined   : 8E1 frames, a parity state sits between DATA and STOP and a
//               parity mismatch rejects the frame like a bad stop bit
//
// Parameters
//   BAUD_DIV     clk cycles per bit (>= 4)
//   HALF_DIV     cycles from start-bit falling edge to start-bit mid-sample
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   RX           asynchronous serial line, idle high
//   clr_cmd_rdy  one-cycle pulse from the controller consuming cmd
//   cmd          last good byte received
//   cmd_rdy      level, a valid unconsumed byte is present
//   rx_busy      high whenever a frame is being received
//   frm_err      one-cycle pulse on a rejected frame
//   ovr          one-cycle pulse when a good byte overwrites an unconsumed one
// ---------------------------------------------------------------------------
module uart_cmd_rcv #(
    parameter int BAUD_DIV = 2604,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_cmd_rdy,
    output logic [7:0] cmd,
    output logic       cmd_rdy,
    output logic       rx_busy,
    output logic       frm_err,
    output logic       ovr
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF_DIV - 1);

`ifdef CMD_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          r_state;
    logic            r_rxMeta;
    logic            r_rxS;
    logic            r_rxPrev;
    logic [CW-1:0]   r_baudCnt;
    logic [3:0]      r_bitCnt;
    logic [7:0]      r_shReg;
    logic [7:0]      r_cmd;
    logic            r_cmdRdy;
    logic            r_busy;
    logic            r_frmErr;
    logic            r_ovr;
`ifdef CMD_PARITY_EN
    logic            r_parErr;
`endif

    logic            w_fallEdge;
    logic            w_tick;
    logic            w_goodFrame;

    // Two-flop synchronizer on RX plus a delayed copy for edge detection.
    // All three reset high so a reset never fakes a start-bit edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rxMeta <= 1'b1;
            r_rxS    <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_rxMeta <= RX;
            r_rxS    <= r_rxMeta;
            r_rxPrev <= r_rxS;
        end
    end

    // Only a high-to-low transition starts a frame, so a line stuck low
    // cannot retrigger reception.
    assign w_fallEdge = r_rxPrev & ~r_rxS;
    assign w_tick     = (r_state != IDLE) && (r_baudCnt == '0);

`ifdef CMD_PARITY_EN
    assign w_goodFrame = r_rxS & ~r_parErr;
`else
    assign w_goodFrame = r_rxS;
`endif

    // Receive state machine with the baud down-counter, shift register and
    // all registered outputs. The counter is reloaded by whichever state
    // consumes a tick; otherwise it just counts down while busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            r_shReg   <= '0;
            r_cmd     <= '0;
            r_cmdRdy  <= 1'b0;
            r_busy    <= 1'b0;
            r_frmErr  <= 1'b0;
            r_ovr     <= 1'b0;
`ifdef CMD_PARITY_EN
            r_parErr  <= 1'b0;
`endif
        end else begin
            r_frmErr <= 1'b0;
            r_ovr    <= 1'b0;

            // A consume request is applied first so that a good-frame set
            // later in this block overrides it in the same cycle.
            if (clr_cmd_rdy) begin
                r_cmdRdy <= 1'b0;
            end

            if ((r_state != IDLE) && (r_baudCnt != '0)) begin
                r_baudCnt <= r_baudCnt - CW'(1);
            end

            case (r_state)
                IDLE: begin
                    if (w_fallEdge) begin
                        r_state   <= START;
                        r_baudCnt <= HALF_RELOAD;
                        r_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_rxS) begin
                            // Glitch shorter than half a bit: drop it silently.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= DATA;
                            r_baudCnt <= BAUD_RELOAD;
                            r_bitCnt  <= '0;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shReg   <= {r_rxS, r_shReg[7:1]};
                        r_bitCnt  <= r_bitCnt + 4'd1;
                        r_baudCnt <= BAUD_RELOAD;
                        if (r_bitCnt == 4'd7) begin
`ifdef CMD_PARITY_EN
                            r_state <= PAR;
`else
                            r_state <= STOP;
`endif
                        end
                    end
                end
`ifdef CMD_PARITY_EN
                PAR: begin
                    if (w_tick) begin
                        // Even parity: data bits plus parity bit must XOR to 0.
                        r_parErr  <= (^r_shReg) ^ r_rxS;
                        r_baudCnt <= BAUD_RELOAD;
                        r_state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (w_goodFrame) begin
                            r_cmd    <= r_shReg;
                            r_cmdRdy <= 1'b1;
                            r_ovr    <= r_cmdRdy;
                        end else begin
                            r_frmErr <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmdRdy;
    assign rx_busy = r_busy;
    assign frm_err = r_frmErr;
    assign ovr     = r_ovr;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_rcv
// Self-checking bench for uart_cmd_rcv at BAUD_DIV=16. A directed table of
// frames is followed by hand-written corner cases (glitch, mid-frame reset,
// parity reject) and a randomized run checked against a frame-level model
// that only tracks "last good byte" and "unconsumed flag".
// Honors CMD_PARITY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_uart_cmd_rcv;

    localparam int BIT = 16;
`ifdef CMD_PARITY_EN
    localparam bit PARITY     = 1'b1;
    localparam int FRAME_BITS = 11;
`else
    localparam bit PARITY     = 1'b0;
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * BIT;
    // Stop-bit middle plus two synchronizer cycles plus one register cycle.
    localparam int LAT = BIT * (FRAME_BITS - 1) + BIT / 2 + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RX;
    logic       clr_cmd_rdy;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       rx_busy;
    logic       frm_err;
    logic       ovr;

    int nCompared   = 0;
    int nMismatched = 0;

    // Frame-level reference state
    logic [7:0] mCmd;
    logic       mRdy;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic       clrBefore;
        logic       clrAtSet;
        logic [7:0] expCmd;
        logic       expRdy;
        int         expOvr;
        int         expFrm;
    } vec_t;

    vec_t vecs[7];

    uart_cmd_rcv #(.BAUD_DIV(BIT), .HALF_DIV(BIT / 2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .rx_busy     (rx_busy),
        .frm_err     (frm_err),
        .ovr         (ovr)
    );

    always #5 clk = ~clk;

    // One comparison; prints a FAIL line on mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one full frame starting just after a rising edge, then idle.
    // Collects pulse counts and cmd_rdy/cmd around the expected update edge.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic badPar,
                                 input logic clrAtSet, output logic rdyBefore, output logic rdyAt,
                                 output logic [7:0] cmdAt, output logic busyMid,
                                 output int frmCnt, output int ovrCnt);
        logic [10:0] frame;
        logic        parBit;
        int          idx;
        parBit = (^data) ^ badPar;
        if (PARITY) frame = {stopBit, parBit, data, 1'b0};
        else        frame = {1'b1, stopBit, data, 1'b0};
        frmCnt = 0; ovrCnt = 0; rdyBefore = 1'b0; rdyAt = 1'b0; cmdAt = 8'h00; busyMid = 1'b0;
        @(posedge clk); #1 RX = frame[0];
        for (int k = 1; k < FRAME_CYC + 8; k++) begin
            @(posedge clk); #1;
            idx = k / BIT;
            RX = (idx < FRAME_BITS) ? frame[idx] : 1'b1;
            if (k == LAT - 1) clr_cmd_rdy = clrAtSet;
            if (k == LAT)     clr_cmd_rdy = 1'b0;
            @(negedge clk);
            if (frm_err) frmCnt++;
            if (ovr)     ovrCnt++;
            if (k == LAT - 1) rdyBefore = cmd_rdy;
            if (k == LAT) begin
                rdyAt = cmd_rdy;
                cmdAt = cmd;
            end
            if (k == BIT * 4) busyMid = rx_busy;
        end
    endtask

    // Controller consumes the byte with a single-cycle pulse
    task automatic pulseClr();
        @(posedge clk); #1 clr_cmd_rdy = 1'b1;
        @(posedge clk); #1 clr_cmd_rdy = 1'b0;
        @(negedge clk);
        mRdy = 1'b0;
        checkOutput("clr_rdy", {31'd0, cmd_rdy}, 32'd0);
        checkOutput("clr_cmd_hold", {24'd0, cmd}, {24'd0, mCmd});
    endtask

    // Frame-level reference: a good frame latches the byte, flags overrun
    // if the previous one was unconsumed; a bad frame only pulses frm_err.
    task automatic modelFrame(input logic [7:0] data, input logic stopBit, input logic badPar,
                              input logic clrAtSet, output logic expBefore, output logic expRdy,
                              output logic [7:0] expCmd, output int expOvr, output int expFrm);
        logic good;
        expBefore = mRdy;
        good = stopBit && !(PARITY && badPar);
        if (good) begin
            expOvr = mRdy ? 1 : 0;
            expFrm = 0;
            mCmd   = data;
            mRdy   = 1'b1;
        end else begin
            expOvr = 0;
            expFrm = 1;
            if (clrAtSet) mRdy = 1'b0;
        end
        expRdy = mRdy;
        expCmd = mCmd;
    endtask

    // Send a frame and compare every observation with the given expectations
    task automatic runFrame(input string tag, input logic [7:0] data, input logic stopBit,
                            input logic badPar, input logic clrAtSet, input logic expBefore,
                            input logic expRdy, input logic [7:0] expCmd, input int expOvr,
                            input int expFrm);
        logic       rdyBefore, rdyAt, busyMid;
        logic [7:0] cmdAt;
        int         frmCnt, ovrCnt;
        applyStimulus(data, stopBit, badPar, clrAtSet, rdyBefore, rdyAt, cmdAt, busyMid, frmCnt, ovrCnt);
        checkOutput({tag, "_rdy_before"}, {31'd0, rdyBefore}, {31'd0, expBefore});
        checkOutput({tag, "_rdy"}, {31'd0, rdyAt}, {31'd0, expRdy});
        checkOutput({tag, "_cmd"}, {24'd0, cmdAt}, {24'd0, expCmd});
        checkOutput({tag, "_ovr_pulses"}, ovrCnt, expOvr);
        checkOutput({tag, "_frm_pulses"}, frmCnt, expFrm);
        checkOutput({tag, "_busy_mid"}, {31'd0, busyMid}, 32'd1);
        checkOutput({tag, "_busy_idle"}, {31'd0, rx_busy}, 32'd0);
    endtask

    initial begin
        logic       eBefore, eRdy;
        logic [7:0] eCmd;
        int         eOvr, eFrm;
        logic [7:0] rData;
        logic       rStop, rBad, rClrB, rClrS;
        int         glitchFrm;

        vecs[0] = '{8'h70, 1'b1, 1'b0, 1'b0, 8'h70, 1'b1, 0, 0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 0, 0};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 0, 0};
        vecs[3] = '{8'hC3, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1, 1, 0};
        vecs[4] = '{8'h96, 1'b1, 1'b0, 1'b1, 8'h96, 1'b1, 1, 0};
        vecs[5] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h96, 1'b1, 0, 1};
        vecs[6] = '{8'h11, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0};

        rst_n = 1'b0;
        RX = 1'b1;
        clr_cmd_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        mCmd = 8'h00;
        mRdy = 1'b0;
        checkOutput("reset_cmd", {24'd0, cmd}, 32'd0);
        checkOutput("reset_rdy", {31'd0, cmd_rdy}, 32'd0);
        checkOutput("reset_busy", {31'd0, rx_busy}, 32'd0);
        checkOutput("reset_frm", {31'd0, frm_err}, 32'd0);
        checkOutput("reset_ovr", {31'd0, ovr}, 32'd0);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].clrBefore) pulseClr();
            modelFrame(vecs[i].data, vecs[i].stopBit, 1'b0, vecs[i].clrAtSet, eBefore, eRdy, eCmd, eOvr, eFrm);
            runFrame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stopBit, 1'b0, vecs[i].clrAtSet,
                     eBefore, vecs[i].expRdy, vecs[i].expCmd, vecs[i].expOvr, vecs[i].expFrm);
        end

        // Short low glitch must be rejected at the half-bit sample
        glitchFrm = 0;
        @(posedge clk); #1 RX = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        RX = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("glitch_busy_start", {31'd0, rx_busy}, 32'd1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (frm_err) glitchFrm++;
        end
        checkOutput("glitch_busy_end", {31'd0, rx_busy}, 32'd0);
        checkOutput("glitch_frm", glitchFrm, 0);
        checkOutput("glitch_rdy", {31'd0, cmd_rdy}, {31'd0, mRdy});
        checkOutput("glitch_cmd", {24'd0, cmd}, {24'd0, mCmd});

        // Reset in the middle of the data bits
        @(posedge clk); #1 RX = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput("midrst_busy_before", {31'd0, rx_busy}, 32'd1);
        @(posedge clk); #1;
        RX = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        mCmd = 8'h00;
        mRdy = 1'b0;
        checkOutput("midrst_cmd", {24'd0, cmd}, 32'd0);
        checkOutput("midrst_rdy", {31'd0, cmd_rdy}, 32'd0);
        checkOutput("midrst_busy", {31'd0, rx_busy}, 32'd0);
        modelFrame(8'h27, 1'b1, 1'b0, 1'b0, eBefore, eRdy, eCmd, eOvr, eFrm);
        runFrame("after_rst", 8'h27, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h27, 0, 0);

        if (PARITY) begin
            pulseClr();
            modelFrame(8'h27, 1'b1, 1'b1, 1'b0, eBefore, eRdy, eCmd, eOvr, eFrm);
            runFrame("bad_parity", 8'h27, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h27, 0, 1);
        end

        // Randomized frames against the frame-level model
        for (int n = 0; n < 16; n++) begin
            rData = 8'($urandom_range(0, 255));
            rStop = ($urandom_range(0, 3) != 0);
            rBad  = PARITY && ($urandom_range(0, 3) == 0);
            rClrB = 1'($urandom_range(0, 1));
            rClrS = 1'($urandom_range(0, 1));
            if (rClrB) pulseClr();
            repeat ($urandom_range(0, 5)) @(posedge clk);
            modelFrame(rData, rStop, rBad, rClrS, eBefore, eRdy, eCmd, eOvr, eFrm);
            runFrame($sformatf("rnd%0d", n), rData, rStop, rBad, rClrS, eBefore, eRdy, eCmd, eOvr, eFrm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rcv.md
Name: uart_cmd_rcv

Overview:
- 8N1 UART receiver; the upstream stage that feeds the command controller its cmd byte and cmd_rdy.
- Samples the asynchronous serial line from the wireless/host link and assembles bytes.
- Holds each byte with a level cmd_rdy until the controller pulses clr_cmd_rdy.
- Flags framing errors and overruns so the controller can ignore corrupt commands.

Parameters:
- BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200 baud); legal range ≥ 4.
- HALF_DIV, BAUD_DIV/2, cycles from start-bit falling edge to start-bit mid-sample.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- RX  input  1  asynchronous serial line, idle high
- clr_cmd_rdy  input  1  one-cycle pulse from controller consuming cmd
- cmd  output  8  last good byte received
- cmd_rdy  output  1  level; a valid unconsumed byte is present
- rx_busy  output  1  high whenever the state is not IDLE
- frm_err  output  1  one-cycle pulse on a bad stop bit
- ovr  output  1  one-cycle pulse when a good byte overwrites an unconsumed one

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, cmd=0, cmd_rdy=0, frm_err=0, ovr=0, rx_busy=0.
  - Both synchronizer flops and the edge-detect flop reset to 1.
  - Counters reset to 0.
  - Reset mid-frame discards the partial byte.
- RX is passed through a 2-flop synchronizer (rx_s). Falling edge = rx_s==0 while the previous rx_s==1.
- Baud counter is a down-counter. A "tick" occurs when it is 0 and the state is not IDLE; the counter reloads on every tick.
- States:
  - IDLE: on falling edge go to START and load the counter with HALF_DIV-1. A line held low never retriggers.
  - START: on tick sample rx_s.
    - 1: false start; go to IDLE with no outputs changed.
    - 0: load BAUD_DIV-1, clear bit_cnt, go to DATA.
  - DATA: on tick shift rx_s into shreg[7] (LSB first, shift right), bit_cnt++, reload BAUD_DIV-1. After the 8th bit go to STOP (or PAR when CMD_PARITY_EN).
  - STOP: on tick sample rx_s.
    - 1: good frame. Next cycle cmd=shreg and cmd_rdy=1. ovr pulses for 1 cycle if cmd_rdy was already 1.
    - 0: frm_err pulses for 1 cycle; cmd and cmd_rdy unchanged.
    - Either case: go to IDLE.
- Latency: cmd/cmd_rdy are valid on the first clk edge after the stop-bit mid-sample, i.e. 9.5 bit times + 3 cycles after the start-bit falling edge at the RX pin (2 sync cycles + 1 register cycle).
- cmd_rdy priority: a good-frame set beats a simultaneous clr_cmd_rdy, so the new byte stays flagged. clr_cmd_rdy while cmd_rdy=0 has no effect.
- cmd is stable whenever cmd_rdy=1, except on an overrun overwrite.
- A new start bit while cmd_rdy=1 is accepted; receiving never stalls.
- bit_cnt is 4 bits and never wraps past 8 within a frame.

Optional Feature:
- Macro CMD_PARITY_EN.
- Defined:
  - Frame is 8E1. A PAR state between DATA and STOP samples the parity bit on tick.
  - If XOR(shreg, parity bit) is 1, the frame is rejected: frm_err pulses at the stop tick and cmd/cmd_rdy are unchanged, even if the stop bit is good.
  - Frame is 11 bits; latency grows by 1 bit time.
- Undefined: pure 8N1; no PAR state or parity logic is synthesized.

Test Plan (BAUD_DIV=16 in sim):
- Reset, RX idle 1 -> cmd=0x00, cmd_rdy=0, rx_busy=0. Send 0x70, stop=1 -> cmd=0x70, cmd_rdy=1 exactly 155 cycles (9.5×16+3) after the falling edge. No frm_err.
- cmd_rdy=1, pulse clr_cmd_rdy -> cmd_rdy=0 next cycle, cmd holds 0x70. Then send 0xA5 -> cmd=0xA5, cmd_rdy=1.
- Send 0x3C unconsumed, then 0xC3 -> ovr pulses once, cmd=0xC3, cmd_rdy=1. Repeat with clr_cmd_rdy in the same cycle as the set -> cmd_rdy stays 1.
- RX low glitch of 4 cycles -> START rejects at the half-bit sample. State returns to IDLE; no cmd_rdy, no frm_err.
- Send 0x55 with stop bit=0 -> frm_err one-cycle pulse, cmd/cmd_rdy unchanged. A following good 0x11 is received correctly.
- Assert rst_n=0 for 1 cycle mid-DATA -> all outputs return to reset values at that edge; the next full frame 0x27 is received correctly. With CMD_PARITY_EN, 0x27 sent with a wrong parity bit -> frm_err and no cmd_rdy.
